// File: rtl/jt7759_seq.sv
// jt7759 phrase sequencer: walks block headers in sample ROM and feeds the
// ADPCM decoder one nibble per sample period, with mute/underrun tracking.
module jt7759_seq #(
  parameter int AW = 17
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cen,
  input  logic          cendec,
  input  logic          start,
  input  logic          stop,
  input  logic [AW-1:0] st_addr,
  output logic          rom_cs,
  output logic [AW-1:0] rom_addr,
  input  logic [7:0]    rom_data,
  input  logic          rom_ok,
  output logic [3:0]    dec_data,
  output logic          dec_we,
  output logic          dec_rst,
  output logic          muted,
  output logic          busy,
  output logic          done,
  output logic          underrun
);

  // state   | meaning
  // IDLE    | no phrase active, decoder muted
  // HDR     | fetching a block header byte
  // LEN     | fetching the nibble count of a counted block
  // SIL     | muted for silcnt+1 sample periods
  // PLAY    | delivering nibbles, one per sample event
  // END     | end header seen, done pulse, back to IDLE
  typedef enum logic [2:0] {
    ST_IDLE, ST_HDR, ST_LEN, ST_SIL, ST_PLAY, ST_END
  } state_t;

  state_t          state, state_nxt;
  logic            rom_cs_nxt;
  logic [AW-1:0]   rom_addr_nxt;
  logic [3:0]      dec_data_nxt;
  logic            dec_we_nxt, dec_rst_nxt, muted_nxt, busy_nxt, done_nxt, underrun_nxt;
  logic [5:0]      div, div_nxt, cnt, cnt_nxt, silcnt, silcnt_nxt;
  logic [8:0]      nrem, nrem_nxt;
  logic [7:0]      bbuf, bbuf_nxt, cur_byte;
  logic            bvalid, bvalid_nxt, half, half_nxt;
  logic            tick, ev, got, want, have, cur_lo;

  assign tick = cen & cendec;
  assign ev   = tick && (cnt == div);
  assign got  = rom_cs & rom_ok;
  assign want = (state == ST_HDR) || (state == ST_LEN) ||
                ((state == ST_PLAY) && !bvalid && (nrem != 9'd0));

  always_comb begin
    state_nxt    = state;
    rom_cs_nxt   = rom_cs;
    rom_addr_nxt = rom_addr;
    dec_data_nxt = dec_data;
    dec_we_nxt   = 1'b0;
    dec_rst_nxt  = 1'b0;
    done_nxt     = 1'b0;
    underrun_nxt = underrun;
    div_nxt      = div;
    silcnt_nxt   = silcnt;
    nrem_nxt     = nrem;
    bbuf_nxt     = bbuf;
    bvalid_nxt   = bvalid;
    half_nxt     = half;
    have         = bvalid | got;
    cur_byte     = bvalid ? bbuf : rom_data;
    cur_lo       = bvalid & half;
    cnt_nxt      = cnt;
    if (tick) cnt_nxt = ev ? 6'd0 : cnt + 6'd1;

    if (got) begin
      rom_cs_nxt   = 1'b0;
      rom_addr_nxt = rom_addr + {{(AW-1){1'b0}}, 1'b1};
    end else if (!rom_cs && want) begin
      rom_cs_nxt = 1'b1;
    end

    case (state)
      ST_HDR: if (got) begin
        cnt_nxt = 6'd0;
        case (rom_data[7:6])
          2'b00: begin silcnt_nxt = rom_data[5:0]; state_nxt = ST_SIL; end
          2'b01: begin div_nxt = rom_data[5:0]; nrem_nxt = 9'd256; state_nxt = ST_PLAY; end
          2'b10: begin div_nxt = rom_data[5:0]; state_nxt = ST_LEN; end
          default: begin done_nxt = 1'b1; state_nxt = ST_END; end
        endcase
      end
      ST_LEN: if (got) begin
        nrem_nxt  = {1'b0, rom_data} + 9'd1;
        state_nxt = ST_PLAY;
      end
      ST_SIL: if (ev) begin
        if (silcnt == 6'd0) state_nxt = ST_HDR;
        else silcnt_nxt = silcnt - 6'd1;
      end
      ST_PLAY: begin
        if (nrem == 9'd0) begin
          // an odd count leaves the low nibble unplayed; it is simply dropped
          state_nxt  = ST_HDR;
          bvalid_nxt = 1'b0;
          half_nxt   = 1'b0;
        end else if (ev) begin
          if (have) begin
            // a byte landing on the event edge is played straight from rom_data
            dec_data_nxt = cur_lo ? cur_byte[3:0] : cur_byte[7:4];
            dec_we_nxt   = 1'b1;
            nrem_nxt     = nrem - 9'd1;
            if (cur_lo || (nrem == 9'd1)) begin
              bvalid_nxt = 1'b0;
              half_nxt   = 1'b0;
            end else begin
              bbuf_nxt   = cur_byte;
              bvalid_nxt = 1'b1;
              half_nxt   = 1'b1;
            end
          end else begin
            underrun_nxt = 1'b1;
          end
        end else if (got) begin
          bbuf_nxt   = rom_data;
          bvalid_nxt = 1'b1;
          half_nxt   = 1'b0;
        end
      end
      ST_END: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase

    if (start) begin
      state_nxt    = ST_HDR;
      rom_cs_nxt   = 1'b1;
      rom_addr_nxt = st_addr;
      dec_rst_nxt  = 1'b1;
      dec_we_nxt   = 1'b0;
      done_nxt     = 1'b0;
      underrun_nxt = 1'b0;
      bvalid_nxt   = 1'b0;
      half_nxt     = 1'b0;
    end else if (stop) begin
      state_nxt  = ST_IDLE;
      rom_cs_nxt = 1'b0;
      dec_we_nxt = 1'b0;
      done_nxt   = 1'b0;
      bvalid_nxt = 1'b0;
      half_nxt   = 1'b0;
    end

    busy_nxt  = (state_nxt != ST_IDLE);
    muted_nxt = (state_nxt == ST_PLAY) ? (muted & ~dec_we_nxt) : 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      rom_cs   <= 1'b0;
      rom_addr <= '0;
      dec_data <= 4'd0;
      dec_we   <= 1'b0;
      dec_rst  <= 1'b0;
      muted    <= 1'b1;
      busy     <= 1'b0;
      done     <= 1'b0;
      underrun <= 1'b0;
      div      <= 6'd0;
      cnt      <= 6'd0;
      silcnt   <= 6'd0;
      nrem     <= 9'd0;
      bbuf     <= 8'd0;
      bvalid   <= 1'b0;
      half     <= 1'b0;
    end else begin
      state    <= state_nxt;
      rom_cs   <= rom_cs_nxt;
      rom_addr <= rom_addr_nxt;
      dec_data <= dec_data_nxt;
      dec_we   <= dec_we_nxt;
      dec_rst  <= dec_rst_nxt;
      muted    <= muted_nxt;
      busy     <= busy_nxt;
      done     <= done_nxt;
      underrun <= underrun_nxt;
      div      <= div_nxt;
      cnt      <= cnt_nxt;
      silcnt   <= silcnt_nxt;
      nrem     <= nrem_nxt;
      bbuf     <= bbuf_nxt;
      bvalid   <= bvalid_nxt;
      half     <= half_nxt;
    end
  end

endmodule

// File: tb/tb_jt7759_seq.sv
// Bench for jt7759_seq: ROM responder with programmable latency, phrase-level
// nibble model, and a per-cycle monitor comparing decoder writes against it.
module tb_jt7759_seq;
  localparam int AW   = 17;
  localparam int MASK = (1 << AW) - 1;

  logic          clk = 1'b0, rst_n = 1'b0, cen = 1'b0, cendec = 1'b0;
  logic          start = 1'b0, stop = 1'b0;
  logic [AW-1:0] st_addr = '0;
  logic          rom_cs, rom_ok = 1'b0;
  logic [AW-1:0] rom_addr;
  logic [7:0]    rom_data = 8'd0;
  logic [3:0]    dec_data;
  logic          dec_we, dec_rst, muted, busy, done, underrun;

  jt7759_seq #(.AW(AW)) dut (
    .clk(clk), .rst_n(rst_n), .cen(cen), .cendec(cendec), .start(start), .stop(stop),
    .st_addr(st_addr), .rom_cs(rom_cs), .rom_addr(rom_addr), .rom_data(rom_data),
    .rom_ok(rom_ok), .dec_data(dec_data), .dec_we(dec_we), .dec_rst(dec_rst),
    .muted(muted), .busy(busy), .done(done), .underrun(underrun)
  );

  always #5 clk = ~clk;

  logic [7:0] rom [0:(1<<AW)-1];
  int lat = 0, wcnt = 0, last_served = -1;
  int tmode = 0, tper = 1, phase = 0;
  int total = 0, passed = 0;
  int exp_nib[$], exp_per[$], got_nibs[$];
  int exp_done = 0, done_seen = 0, nib_seen = 0;
  int tickctr = 0, last_tick = 0;
  bit exact = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // Expected nibble stream of a whole phrase, derived from the header rules.
  task automatic push_phrase(input int addr);
    int a, n, per;
    logic [7:0] h, b;
    a = addr & MASK;
    for (int g = 0; g < 64; g++) begin
      h = rom[a]; a = (a + 1) & MASK; n = 0; per = 1;
      if (h[7:6] == 2'b11) begin exp_done++; return; end
      if (h[7:6] == 2'b01) begin n = 256; per = int'(h[5:0]) + 1; end
      else if (h[7:6] == 2'b10) begin
        n = int'(rom[a]) + 1; a = (a + 1) & MASK; per = int'(h[5:0]) + 1;
      end
      for (int k = 0; k < n; k++) begin
        b = rom[(a + k/2) & MASK];
        exp_nib.push_back((k % 2) ? int'(b[3:0]) : int'(b[7:4]));
        exp_per.push_back((k == 0) ? 0 : per);
      end
      a = (a + (n + 1)/2) & MASK;
    end
  endtask

  always @(negedge clk) begin
    if (rom_cs) begin
      if (wcnt >= lat) begin rom_ok = 1'b1; rom_data = rom[rom_addr]; end
      else rom_ok = 1'b0;
      wcnt++;
    end else begin
      wcnt = 0; rom_ok = 1'b0;
    end
  end

  always @(negedge clk) begin
    phase++;
    if (tmode == 0) begin cen = ((phase % tper) == 0); cendec = 1'b1; end
    else begin cen = 1'b1; cendec = ((phase % tper) == 0); end
  end

  always @(posedge clk) begin
    bit t;
    int e, p, sp;
    t = cen & cendec;
    if (rom_cs && rom_ok) last_served = int'(rom_addr);
    #1;
    if (t) tickctr++;
    if (rst_n) begin
      if (done) done_seen++;
      if (!busy) chk("idle_muted", int'(muted), 1);
      if (dec_we) begin
        nib_seen++;
        got_nibs.push_back(int'(dec_data));
        chk("we_unmuted", int'(muted), 0);
        if (exp_nib.size() == 0) chk("unexpected_we", 1, 0);
        else begin
          e = exp_nib.pop_front();
          p = exp_per.pop_front();
          chk("nibble", int'(dec_data), e);
          if (p > 0) begin
            sp = tickctr - last_tick;
            if (exact) chk("spacing", sp, p);
            else chk("spacing_mult", int'(sp > 0 && (sp % p) == 0), 1);
          end
        end
        last_tick = tickctr;
      end
    end
  end

  task automatic wait_idle(input int limit);
    int i;
    for (i = 0; i < limit; i++) begin
      @(posedge clk); #2;
      if (!busy) break;
    end
    chk("phrase_timeout", int'(i < limit), 1);
  endtask

  task automatic run_phrase(input int addr, input int limit);
    got_nibs.delete();
    push_phrase(addr);
    @(negedge clk); st_addr = addr[AW-1:0]; start = 1'b1;
    @(negedge clk); start = 1'b0;
    wait_idle(limit);
    chk("leftover_nibbles", exp_nib.size(), 0);
  endtask

  task automatic load_fix(input int base);
    rom[base] = 8'h40;
    for (int i = 0; i < 128; i++) rom[base + 1 + i] = 8'((i * 37 + 165) & 255);
    rom[base + 129] = 8'hFF;
  endtask

  task automatic load_cnt(input int base, input logic [7:0] b0, input logic [7:0] b1);
    rom[base] = 8'h81; rom[base + 1] = 8'h02; rom[base + 2] = b0;
    rom[base + 3] = b1; rom[base + 4] = 8'hFF;
  endtask

  initial begin
    int d0, n0, i;
    for (int k = 0; k < (1 << AW); k++) rom[k] = 8'h00;
    repeat (3) @(negedge clk);
    chk("rst_rom_cs", int'(rom_cs), 0);
    chk("rst_rom_addr", int'(rom_addr), 0);
    chk("rst_dec_data", int'(dec_data), 0);
    chk("rst_dec_we", int'(dec_we), 0);
    chk("rst_dec_rst", int'(dec_rst), 0);
    chk("rst_muted", int'(muted), 1);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_underrun", int'(underrun), 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // T1: silence then end, tick every clock
    rom[0] = 8'h03; rom[1] = 8'hFF;
    tmode = 0; tper = 1; exact = 1'b1;
    d0 = done_seen; n0 = nib_seen;
    run_phrase(0, 200);
    chk("t1_done", done_seen - d0, 1);
    chk("t1_no_we", nib_seen - n0, 0);
    chk("t1_end_addr", last_served, 1);
    chk("t1_underrun", int'(underrun), 0);

    // T2: counted block, odd count, div=1
    load_cnt('h10, 8'hAB, 8'hCD);
    d0 = done_seen;
    run_phrase('h10, 300);
    chk("t2_count", got_nibs.size(), 3);
    chk("t2_n0", (got_nibs.size() > 0) ? got_nibs[0] : -1, 'hA);
    chk("t2_n1", (got_nibs.size() > 1) ? got_nibs[1] : -1, 'hB);
    chk("t2_n2", (got_nibs.size() > 2) ? got_nibs[2] : -1, 'hC);
    chk("t2_end_addr", last_served, 'h14);
    chk("t2_done", done_seen - d0, 1);
    chk("t2_underrun", int'(underrun), 0);

    // T3: fixed 256-nibble block, tick driven by cendec every 2nd clock
    load_fix('h1000);
    tmode = 1; tper = 2; exact = 1'b0;
    d0 = done_seen; n0 = nib_seen;
    run_phrase('h1000, 5000);
    chk("t3_we_count", nib_seen - n0, 256);
    chk("t3_n0", (got_nibs.size() > 0) ? got_nibs[0] : -1, 'hA);
    chk("t3_n1", (got_nibs.size() > 1) ? got_nibs[1] : -1, 'h5);
    chk("t3_done", done_seen - d0, 1);

    // T4: slow ROM, tick every 4 clocks
    load_cnt('h20, 8'hAB, 8'hCD);
    lat = 40; tmode = 0; tper = 4;
    d0 = done_seen;
    run_phrase('h20, 3000);
    chk("t4_underrun", int'(underrun), 1);
    chk("t4_count", got_nibs.size(), 3);
    chk("t4_n0", (got_nibs.size() > 0) ? got_nibs[0] : -1, 'hA);
    chk("t4_n1", (got_nibs.size() > 1) ? got_nibs[1] : -1, 'hB);
    chk("t4_n2", (got_nibs.size() > 2) ? got_nibs[2] : -1, 'hC);
    chk("t4_done", done_seen - d0, 1);
    lat = 0;

    // T5: restart mid-PLAY, then stop mid-PLAY
    load_fix('h100);
    load_cnt('h400, 8'h12, 8'h34);
    tper = 1;
    d0 = done_seen; n0 = nib_seen;
    push_phrase('h100);
    @(negedge clk); st_addr = AW'('h100); start = 1'b1;
    @(negedge clk); start = 1'b0;
    for (i = 0; i < 500; i++) begin
      @(posedge clk); #2;
      if (nib_seen >= n0 + 10) break;
    end
    chk("t5_first_play", int'(i < 500), 1);
    @(negedge clk);
    exp_nib.delete(); exp_per.delete(); exp_done = done_seen;
    got_nibs.delete();
    push_phrase('h400);
    st_addr = AW'('h400); start = 1'b1;
    @(posedge clk); #2;
    chk("t5_dec_rst", int'(dec_rst), 1);
    chk("t5_busy", int'(busy), 1);
    chk("t5_underrun_clr", int'(underrun), 0);
    chk("t5_rom_addr", int'(rom_addr), 'h400);
    chk("t5_muted", int'(muted), 1);
    @(negedge clk); start = 1'b0;
    @(posedge clk); #2;
    chk("t5_dec_rst_pulse", int'(dec_rst), 0);
    for (i = 0; i < 200; i++) begin
      @(posedge clk); #2;
      if (exp_nib.size() <= 1) break;
    end
    chk("t5_second_play", int'(i < 200), 1);
    @(negedge clk);
    exp_nib.delete(); exp_per.delete(); exp_done = done_seen;
    stop = 1'b1;
    @(posedge clk); #2;
    chk("t5_stop_busy", int'(busy), 0);
    chk("t5_stop_muted", int'(muted), 1);
    chk("t5_stop_rom_cs", int'(rom_cs), 0);
    @(negedge clk); stop = 1'b0;
    repeat (40) @(negedge clk);
    chk("t5_new_nibs", got_nibs.size(), 2);
    chk("t5_new_n0", (got_nibs.size() > 0) ? got_nibs[0] : -1, 'h1);
    chk("t5_no_done", done_seen - d0, 0);

    // T6: phrase starting at the top of ROM, address wraps to 0
    rom['h1FFFF] = 8'h81; rom[0] = 8'h01; rom[1] = 8'h5A; rom[2] = 8'hFF;
    exact = 1'b1;
    d0 = done_seen;
    run_phrase('h1FFFF, 300);
    chk("t6_count", got_nibs.size(), 2);
    chk("t6_n0", (got_nibs.size() > 0) ? got_nibs[0] : -1, 'h5);
    chk("t6_n1", (got_nibs.size() > 1) ? got_nibs[1] : -1, 'hA);
    chk("t6_end_addr", last_served, 2);
    chk("t6_rom_addr", int'(rom_addr), 3);
    chk("t6_done", done_seen - d0, 1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
